// File: rtl/cordic_ln_pkg.sv
// Shared constants, micro-rotation tables and FSM states for the
// hyperbolic vectoring CORDIC ln unit.
package cordic_ln_pkg;

    localparam int A_W    = 8;
    localparam int LN_W   = 7;
    localparam int GUARD  = 2;
    localparam int Z_FRAC = 8;
    localparam int STEPS  = 7;

    localparam int XY_W = A_W + 2 + GUARD;
    localparam int Z_W  = Z_FRAC + 2;
    localparam int K_W  = 3;
    localparam int SH_W = 3;

    // 1.0 in the operand's Q3.5 format
    localparam int ONE_Q5 = 32;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ITER,
        OUT
    } state_t;

    // Step 4 repeats shift 4 so the hyperbolic iteration converges.
    function automatic logic [SH_W-1:0] shift_of(input logic [K_W-1:0] k);
        logic [SH_W-1:0] s;
        case (k)
            3'd0:    s = 3'd1;
            3'd1:    s = 3'd2;
            3'd2:    s = 3'd3;
            3'd3:    s = 3'd4;
            3'd4:    s = 3'd4;
            3'd5:    s = 3'd5;
            3'd6:    s = 3'd6;
            default: s = 3'd6;
        endcase
        return s;
    endfunction

    function automatic logic signed [Z_W-1:0] atanh_of(input logic [K_W-1:0] k);
        logic signed [Z_W-1:0] t;
        case (k)
            3'd0:    t = 10'sd141;
            3'd1:    t = 10'sd65;
            3'd2:    t = 10'sd32;
            3'd3:    t = 10'sd16;
            3'd4:    t = 10'sd16;
            3'd5:    t = 10'sd8;
            3'd6:    t = 10'sd4;
            default: t = 10'sd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cordic_ln_vectoring_8bit_stage.sv
// One hyperbolic vectoring micro-rotation: drives y toward zero and
// accumulates the corresponding atanh angle into z.
module cordic_hyp_vec_stage
    import cordic_ln_pkg::*;
(
    input  logic signed [XY_W-1:0] x,
    input  logic signed [XY_W-1:0] y,
    input  logic signed [Z_W-1:0]  z,
    input  logic        [SH_W-1:0] shift,
    input  logic signed [Z_W-1:0]  atanh,
    output logic signed [XY_W-1:0] x_next,
    output logic signed [XY_W-1:0] y_next,
    output logic signed [Z_W-1:0]  z_next
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;

    always_comb begin
        x_sh = x >>> shift;
        y_sh = y >>> shift;
        if (y[XY_W-1]) begin
            x_next = x + y_sh;
            y_next = y + x_sh;
            z_next = z - atanh;
        end else begin
            x_next = x - y_sh;
            y_next = y - x_sh;
            z_next = z + atanh;
        end
    end

endmodule

// File: rtl/cordic_ln_vectoring_8bit.sv
// Iterative hyperbolic CORDIC computing ln(a) for an unsigned Q3.5 operand,
// one micro-rotation per clock behind a start/busy/done handshake.
module cordic_ln_vectoring_8bit
    import cordic_ln_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [A_W-1:0]  a_i,
    output logic            busy,
    output logic            done,
    output logic [LN_W-1:0] ln_o,
    output logic            err_o
);

    localparam logic signed [Z_W:0] LN_MAX = 11'sd63;
    localparam logic signed [Z_W:0] LN_MIN = -11'sd64;

    state_t state;
    state_t state_nxt;

    logic        [A_W-1:0]  a_reg;
    logic signed [XY_W-1:0] x;
    logic signed [XY_W-1:0] y;
    logic signed [Z_W-1:0]  z;
    logic        [K_W-1:0]  k;
    logic                   range_err;

    logic signed [XY_W-1:0] x_next;
    logic signed [XY_W-1:0] y_next;
    logic signed [Z_W-1:0]  z_next;

    logic signed [XY_W-1:0] a_ext;
    logic signed [Z_W:0]    z_wide;
    logic signed [Z_W:0]    z_rnd;
    logic        [LN_W-1:0] ln_calc;

    cordic_hyp_vec_stage u_stage (
        .x      (x),
        .y      (y),
        .z      (z),
        .shift  (shift_of(k)),
        .atanh  (atanh_of(k)),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

    assign busy  = (state != IDLE);
    assign a_ext = {{(XY_W-A_W){1'b0}}, a_reg};

    // ln = 2z; z is Q.8 and ln_o is Q.4, so divide by 8 with round-half-up.
    always_comb begin
        z_wide = {z[Z_W-1], z};
        z_rnd  = (z_wide + 11'sd4) >>> 3;
        if (z_rnd > LN_MAX) begin
            ln_calc = LN_MAX[LN_W-1:0];
        end else if (z_rnd < LN_MIN) begin
            ln_calc = LN_MIN[LN_W-1:0];
        end else begin
            ln_calc = z_rnd[LN_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = INIT;
            INIT: state_nxt = ITER;
            ITER: if (k == K_W'(STEPS-1)) state_nxt = OUT;
            OUT:  state_nxt = start ? INIT : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            k         <= '0;
            range_err <= 1'b0;
            done      <= 1'b0;
            ln_o      <= '0;
            err_o     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) a_reg <= a_i;
                end
                INIT: begin
                    x         <= (a_ext + XY_W'(ONE_Q5)) <<< GUARD;
                    y         <= (a_ext - XY_W'(ONE_Q5)) <<< GUARD;
                    z         <= '0;
                    k         <= '0;
                    range_err <= (a_reg < A_W'(4));
                end
                ITER: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    k <= k + 1'b1;
                end
                OUT: begin
                    done  <= 1'b1;
                    ln_o  <= range_err ? LN_MIN[LN_W-1:0] : ln_calc;
                    err_o <= range_err;
                    // Back-to-back: a new operand can be accepted on the done edge.
                    if (start) a_reg <= a_i;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_ln_vectoring_8bit.sv
// Self-checking bench for cordic_ln_vectoring_8bit: vector table, scoreboard
// queue filled at stimulus time and drained on each done pulse.
module tb_cordic_ln_vectoring_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_i;
    logic       busy;
    logic       done;
    logic [6:0] ln_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] a;
        int         exp_ln;
        bit         exp_err;
        int         tol;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];

    cordic_ln_vectoring_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_i   (a_i),
        .busy  (busy),
        .done  (done),
        .ln_o  (ln_o),
        .err_o (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t ref_of(input int a);
        vec_t v;
        real  r;
        v.a = 8'(a);
        if (a < 4) begin
            v.exp_ln  = -64;
            v.exp_err = 1'b1;
            v.tol     = 0;
        end else begin
            r = 16.0 * $ln(real'(a) / 32.0);
            v.exp_ln  = $rtoi((r >= 0.0) ? r + 0.5 : r - 0.5);
            v.exp_err = 1'b0;
            v.tol     = 1;
        end
        return v;
    endfunction

    // Scoreboard drain on each done pulse.
    always @(negedge clk) begin
        vec_t e;
        int   act;
        int   diff;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: ln_o=%0d err_o=%0d, expected no done", $signed(ln_o), err_o);
            end else begin
                e    = sb.pop_front();
                act  = int'($signed(ln_o));
                diff = act - e.exp_ln;
                checks++;
                if (diff > e.tol || diff < -e.tol) begin
                    errors++;
                    $display("FAIL ln a=%0d: got %0d, expected %0d +/-%0d", e.a, act, e.exp_ln, e.tol);
                end
                chk($sformatf("err a=%0d", e.a), int'(err_o), int'(e.exp_err));
            end
        end
    end

    task automatic run_one(input vec_t v);
        int n;
        int busy_n;
        sb.push_back(v);
        @(negedge clk);
        a_i   = v.a;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a_i    = 8'($urandom);
        n      = 0;
        busy_n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
            if (n <= 8 && busy) busy_n++;
        end
        chk($sformatf("latency a=%0d", v.a), n, 9);
        chk($sformatf("busy_cycles a=%0d", v.a), busy_n, 8);
        chk($sformatf("busy_at_done a=%0d", v.a), int'(busy), 0);
        @(negedge clk);
        chk($sformatf("done_pulse a=%0d", v.a), int'(done), 0);
    endtask

    initial begin
        int   base;
        vec_t v;

        tbl[0] = '{8'd32,  0,   1'b0, 1};
        tbl[1] = '{8'd87,  16,  1'b0, 1};
        tbl[2] = '{8'd16,  -11, 1'b0, 1};
        tbl[3] = '{8'd255, 33,  1'b0, 1};
        tbl[4] = '{8'd3,   -64, 1'b1, 0};
        tbl[5] = '{8'd0,   -64, 1'b1, 0};
        tbl[6] = '{8'd64,  11,  1'b0, 1};
        tbl[7] = '{8'd4,   -33, 1'b0, 1};
        tbl[8] = '{8'd128, 22,  1'b0, 1};
        tbl[9] = '{8'd5,   -30, 1'b0, 1};

        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ln", int'(ln_o), 0);
        chk("reset_err", int'(err_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_one(tbl[i]);

        // start held high, operand changing each cycle
        base = done_cnt;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            a_i   = 8'($urandom);
            start = 1'b1;
            if (c % 9 == 0) sb.push_back(ref_of(int'(a_i)));
        end
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 15 && done_cnt - base < 3; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("b2b_done_count", done_cnt - base, 3);

        // reset in the middle of ITER
        @(negedge clk);
        a_i   = 8'd87;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        base  = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_ln", int'(ln_o), 0);
        chk("midrst_err", int'(err_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_cnt - base, 0);
        run_one(tbl[6]);

        for (int a = 0; a < 256; a++) begin
            v = ref_of(a);
            run_one(v);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
